// File: rtl/demux_vc_router.sv
// Routes each 10-bit word by its [9:8] destination into one of four lane FIFOs.
// One-clock read latency per lane; a push to a full lane without a same-cycle pop is dropped and counted.
module demux_vc_router #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              state,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic [3:0]        pop,
  output logic [DATA_W-1:0] Out0,
  output logic [DATA_W-1:0] Out1,
  output logic [DATA_W-1:0] Out2,
  output logic [DATA_W-1:0] Out3,
  output logic [3:0]        valid,
  output logic [3:0]        empty,
  output logic [3:0]        full,
  output logic              error,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem     [4][DEPTH];
  logic [ADDR_W-1:0] wr_ptr  [4];
  logic [ADDR_W-1:0] rd_ptr  [4];
  logic [ADDR_W:0]   cnt     [4];
  logic [ADDR_W:0]   cnt_nxt [4];
  logic [DATA_W-1:0] out_q   [4];
  logic [1:0]        dest;
  logic [3:0]        do_push;
  logic [3:0]        do_pop;
  logic              drop;

  assign Out0 = out_q[0];
  assign Out1 = out_q[1];
  assign Out2 = out_q[2];
  assign Out3 = out_q[3];

  // A pop only reads an existing entry, so an empty lane never falls through.
  always_comb begin
    dest    = data_in[DATA_W-1:DATA_W-2];
    do_push = '0;
    do_pop  = '0;
    drop    = 1'b0;
    for (int n = 0; n < 4; n++) begin
      do_pop[n]  = state & pop[n] & (cnt[n] != '0);
      cnt_nxt[n] = cnt[n];
    end
    if (state && push) begin
      if (cnt[dest] != CNT_FULL || pop[dest]) do_push[dest] = 1'b1;
      else                                    drop          = 1'b1;
    end
    for (int n = 0; n < 4; n++) begin
      case ({do_push[n], do_pop[n]})
        2'b10:   cnt_nxt[n] = cnt[n] + CNT_ONE;
        2'b01:   cnt_nxt[n] = cnt[n] - CNT_ONE;
        default: cnt_nxt[n] = cnt[n];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (do_push[n]) mem[n][wr_ptr[n]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int n = 0; n < 4; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        cnt[n]    <= '0;
        out_q[n]  <= '0;
      end
      valid    <= '0;
      empty    <= 4'hF;
      full     <= '0;
      error    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (do_push[n]) wr_ptr[n] <= wr_ptr[n] + PTR_ONE;
        if (do_pop[n]) begin
          out_q[n]  <= mem[n][rd_ptr[n]];
          rd_ptr[n] <= rd_ptr[n] + PTR_ONE;
        end
        cnt[n]   <= cnt_nxt[n];
        empty[n] <= (cnt_nxt[n] == '0);
        full[n]  <= (cnt_nxt[n] == CNT_FULL);
      end
      valid <= do_pop;
      error <= drop;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_vc_router.sv
// Bench for demux_vc_router: queue-based lane model checked every cycle, plus directed literal checks.
module tb_demux_vc_router;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_L = 1'b0;
  logic              state = 1'b0;
  logic              push = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [3:0]        pop = '0;
  logic [DATA_W-1:0] Out0, Out1, Out2, Out3;
  logic [3:0]        valid, empty, full;
  logic              error;
  logic [7:0]        drop_cnt;

  demux_vc_router #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(2)) dut (
    .clk(clk), .reset_L(reset_L), .state(state), .push(push), .data_in(data_in),
    .pop(pop), .Out0(Out0), .Out1(Out1), .Out2(Out2), .Out3(Out3), .valid(valid),
    .empty(empty), .full(full), .error(error), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef logic [DATA_W-1:0] word_q_t[$];
  word_q_t           mq [4];
  logic [DATA_W-1:0] m_out [4];
  logic [3:0]        m_valid;
  logic              m_err;
  int                m_drop;

  // Model: lanes are plain queues; pops take the pre-edge head, then the push is applied.
  always @(posedge clk) begin
    logic [3:0] nv;
    logic [3:0] me, mf;
    logic       ne;
    int         d, sz;
    if (!reset_L) begin
      for (int n = 0; n < 4; n++) begin
        mq[n].delete();
        m_out[n] = '0;
      end
      m_valid = '0;
      m_err   = 1'b0;
      m_drop  = 0;
    end else begin
      nv = '0;
      ne = 1'b0;
      if (state) begin
        d  = int'(data_in[DATA_W-1:DATA_W-2]);
        sz = mq[d].size();
        for (int n = 0; n < 4; n++) begin
          if (pop[n] && mq[n].size() > 0) begin
            m_out[n] = mq[n].pop_front();
            nv[n] = 1'b1;
          end
        end
        if (push) begin
          if (sz < DEPTH || pop[d]) mq[d].push_back(data_in);
          else begin
            ne = 1'b1;
            if (m_drop < 255) m_drop++;
          end
        end
      end
      m_valid = nv;
      m_err   = ne;
    end
    #2;
    for (int n = 0; n < 4; n++) begin
      me[n] = (mq[n].size() == 0);
      mf[n] = (mq[n].size() == DEPTH);
    end
    check("Out0", Out0, m_out[0]);
    check("Out1", Out1, m_out[1]);
    check("Out2", Out2, m_out[2]);
    check("Out3", Out3, m_out[3]);
    check("valid", valid, m_valid);
    check("empty", empty, me);
    check("full", full, mf);
    check("error", error, m_err);
    check("drop_cnt", drop_cnt, m_drop);
  end

  task automatic cyc(input logic st, input logic ps, input logic [DATA_W-1:0] d, input logic [3:0] pp);
    state   = st;
    push    = ps;
    data_in = d;
    pop     = pp;
    @(posedge clk);
    #3;
  endtask

  initial begin
    logic [DATA_W-1:0] exp2 [4];
    exp2[0] = 10'h201; exp2[1] = 10'h202; exp2[2] = 10'h203; exp2[3] = 10'h20F;

    repeat (2) cyc(0, 0, '0, '0);
    reset_L = 1'b1;
    check("rst_empty", empty, 4'hF);
    check("rst_full", full, 4'h0);
    check("rst_drop", drop_cnt, 8'd0);
    check("rst_valid", valid, 4'h0);

    // One word per lane, then pop all four together.
    cyc(1, 1, 10'b0000000001, 4'h0);
    cyc(1, 1, 10'b0100000011, 4'h0);
    cyc(1, 1, 10'b1000000010, 4'h0);
    cyc(1, 1, 10'b1100100100, 4'h0);
    cyc(1, 0, '0, 4'hF);
    check("t1_out0", Out0, 10'b0000000001);
    check("t1_out1", Out1, 10'b0100000011);
    check("t1_out2", Out2, 10'b1000000010);
    check("t1_out3", Out3, 10'b1100100100);
    check("t1_valid", valid, 4'hF);
    check("t1_empty", empty, 4'hF);

    // Overfill lane 1.
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 1, 10'h100 + DATA_W'(i), 4'h0);
      if (i == 4) check("t2_full1", full[1], 1'b1);
      if (i == 5) begin
        check("t2_err", error, 1'b1);
        check("t2_drop", drop_cnt, 8'd1);
      end
    end
    cyc(1, 0, '0, 4'h0);
    check("t2_err_clr", error, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0, '0, 4'b0010);
      check("t2_out1", Out1, 10'h100 + DATA_W'(i));
      check("t2_valid", valid, 4'b0010);
    end

    // Push into full lane 2 with a same-cycle pop.
    for (int i = 0; i < 4; i++) cyc(1, 1, 10'h200 + DATA_W'(i), 4'h0);
    cyc(1, 1, 10'b1000001111, 4'b0100);
    check("t3_err", error, 1'b0);
    check("t3_full2", full[2], 1'b1);
    check("t3_out2", Out2, 10'h200);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, '0, 4'b0100);
      check("t3_order", Out2, exp2[i]);
    end

    // Hold mode ignores push and pop.
    cyc(1, 1, 10'h3AA, 4'h0);
    cyc(0, 1, 10'b1100010101, 4'hF);
    check("t4_valid", valid, 4'h0);
    check("t4_empty", empty, 4'b0111);
    cyc(1, 0, '0, 4'b1000);
    check("t4_out3", Out3, 10'h3AA);
    check("t4_valid2", valid, 4'b1000);

    // Pop of empty lanes; push to lane 0 is stored without fall-through.
    cyc(1, 1, 10'b0000001000, 4'b1001);
    check("t5_valid", valid, 4'h0);
    cyc(1, 0, '0, 4'b0001);
    check("t5_out0", Out0, 10'b0000001000);
    check("t5_valid2", valid, 4'b0001);

    // Drop counter saturation.
    for (int i = 0; i < 264; i++) cyc(1, 1, {2'b00, 8'(i)}, 4'h0);
    check("sat_drop", drop_cnt, 8'd255);
    check("sat_err", error, 1'b1);
    repeat (4) cyc(1, 0, '0, 4'b0001);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(7) != 0), 1'($urandom_range(1)), DATA_W'($urandom),
          (i % 400 < 200) ? 4'($urandom) & 4'($urandom) : 4'($urandom) | 4'($urandom));
    end

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 8; i++) cyc(1, 1, {2'(i), 8'(i * 3)}, 4'h0);
    reset_L = 1'b0;
    #1;
    check("arst_empty", empty, 4'hF);
    check("arst_valid", valid, 4'h0);
    check("arst_drop", drop_cnt, 8'd0);
    check("arst_full", full, 4'h0);
    cyc(1, 0, '0, 4'h0);
    reset_L = 1'b1;
    cyc(1, 0, '0, 4'hF);
    check("post_valid", valid, 4'h0);
    check("post_empty", empty, 4'hF);
    cyc(1, 0, '0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
